// File: rtl/lfsr_sched.sv
// Round-robin scheduler sharing one XNOR LFSR among NUM_REQ requesters.
// Seeds the LFSR after reset and on request, advances STEPS per grant, counts full-period wraps.
module lfsr_sched #(
    parameter int unsigned         NUM_BITS = 32,
    parameter int unsigned         NUM_REQ  = 4,
    parameter int unsigned         STEPS    = 32,
    parameter logic [NUM_BITS-1:0] SEED     = '0
) (
    input  logic                i_Clk,
    input  logic                i_Rst_n,
    input  logic [NUM_REQ-1:0]  i_Req,
    output logic [NUM_REQ-1:0]  o_Gnt,
    output logic                o_Data_DV,
    output logic [NUM_BITS-1:0] o_Data,
    input  logic                i_Reseed,
    input  logic [NUM_BITS-1:0] i_Seed_Data,
    output logic                o_LFSR_Enable,
    output logic                o_LFSR_Seed_DV,
    output logic [NUM_BITS-1:0] o_LFSR_Seed_Data,
    input  logic [NUM_BITS-1:0] i_LFSR_Data,
    input  logic                i_LFSR_Done,
    output logic                o_Busy,
    output logic [15:0]         o_Wrap_Count
);

    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W  = $clog2(STEPS + 1);
    localparam int unsigned WRAP_W = 16;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_STEP,
        ST_CAPTURE,
        ST_RESEED
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_BITS-1:0] act_seed_q, act_seed_d;
    logic [NUM_BITS-1:0] pend_seed_q, pend_seed_d;
    logic                pend_q, pend_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic                dv_q, dv_d;
    logic [NUM_BITS-1:0] data_q, data_d;
    logic [WRAP_W-1:0]   wrap_q, wrap_d;
    logic                adv_q, adv_d;

    logic                grant_c;
    logic                pick_found_c;
    logic [IDX_W-1:0]    pick_idx_c;
    int unsigned         rr_cand;
    logic                lfsr_en_c;
    logic                lfsr_seed_dv_c;

    // State and datapath registers
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= ST_INIT;
            last_q      <= IDX_W'(NUM_REQ - 1);
            idx_q       <= '0;
            cnt_q       <= '0;
            act_seed_q  <= SEED;
            pend_seed_q <= SEED;
            pend_q      <= 1'b0;
            gnt_q       <= '0;
            dv_q        <= 1'b0;
            data_q      <= '0;
            wrap_q      <= '0;
            adv_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            act_seed_q  <= act_seed_d;
            pend_seed_q <= pend_seed_d;
            pend_q      <= pend_d;
            gnt_q       <= gnt_d;
            dv_q        <= dv_d;
            data_q      <= data_d;
            wrap_q      <= wrap_d;
            adv_q       <= adv_d;
        end
    end

    // Round-robin search starting just after the last winner
    always_comb begin
        pick_found_c = 1'b0;
        pick_idx_c   = '0;
        rr_cand      = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            rr_cand = (32'(last_q) + k) % NUM_REQ;
            if (!pick_found_c && i_Req[IDX_W'(rr_cand)]) begin
                pick_found_c = 1'b1;
                pick_idx_c   = IDX_W'(rr_cand);
            end
        end
    end

    assign grant_c = (state_q == ST_IDLE) && !pend_q && pick_found_c;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:    state_d = ST_IDLE;
            ST_IDLE: begin
                if (pend_q)       state_d = ST_RESEED;
                else if (grant_c) state_d = ST_STEP;
            end
            ST_STEP:    if (cnt_q == CNT_W'(1)) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_IDLE;
            ST_RESEED:  state_d = ST_IDLE;
            default:    state_d = ST_INIT;
        endcase
    end

    // LFSR control decode and datapath updates
    always_comb begin
        lfsr_en_c      = 1'b0;
        lfsr_seed_dv_c = 1'b0;
        last_d         = last_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        act_seed_d     = act_seed_q;
        pend_seed_d    = pend_seed_q;
        pend_d         = pend_q;
        gnt_d          = '0;
        dv_d           = 1'b0;
        data_d         = data_q;
        wrap_d         = wrap_q;

        case (state_q)
            ST_INIT: begin
                lfsr_en_c      = 1'b1;
                lfsr_seed_dv_c = 1'b1;
            end
            ST_STEP: begin
                lfsr_en_c = 1'b1;
                cnt_d     = cnt_q - CNT_W'(1);
            end
            ST_CAPTURE: begin
                data_d = i_LFSR_Data;
                dv_d   = 1'b1;
                gnt_d  = NUM_REQ'(1) << idx_q;
            end
            ST_RESEED: begin
                lfsr_en_c      = 1'b1;
                lfsr_seed_dv_c = 1'b1;
                act_seed_d     = pend_seed_q;
                pend_d         = 1'b0;
            end
            default: ;
        endcase

        if (grant_c) begin
            idx_d  = pick_idx_c;
            last_d = pick_idx_c;
            cnt_d  = CNT_W'(STEPS);
        end

        if (state_q == ST_RESEED) begin
            wrap_d = '0;
        end else if (adv_q && i_LFSR_Done && (wrap_q != '1)) begin
            wrap_d = wrap_q + WRAP_W'(1);
        end

        // A pulse in the RESEED cycle itself re-arms the flag with the new seed
        if (i_Reseed) begin
            pend_d      = 1'b1;
            pend_seed_d = i_Seed_Data;
        end

        adv_d = lfsr_en_c & ~lfsr_seed_dv_c;
    end

    // LFSR controls follow the state; gated so they read 0 while reset is held
    assign o_LFSR_Enable    = lfsr_en_c & i_Rst_n;
    assign o_LFSR_Seed_DV   = lfsr_seed_dv_c & i_Rst_n;
    assign o_LFSR_Seed_Data = (state_q == ST_RESEED) ? pend_seed_q : act_seed_q;
    assign o_Busy           = (state_q != ST_IDLE) & i_Rst_n;

    assign o_Gnt        = gnt_q;
    assign o_Data_DV    = dv_q;
    assign o_Data       = data_q;
    assign o_Wrap_Count = wrap_q;

endmodule

// File: tb/tb_lfsr_sched.sv
// Bench for lfsr_sched: two instances (8-bit/STEPS=4 and 4-bit/STEPS=5), each driving a
// behavioural XNOR LFSR, checked against a transaction-level model of grants, words and wraps.
module tb_lfsr_sched;

    localparam int unsigned NB  = 8;
    localparam int unsigned NR  = 4;
    localparam int unsigned ST  = 4;
    localparam int unsigned WB  = 4;
    localparam int unsigned WST = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [NR-1:0] req_a = '0;
    logic          reseed_a = 1'b0;
    logic [NB-1:0] seed_in_a = '0;
    logic [NR-1:0] gnt_a;
    logic          dv_a, en_a, sdv_a, busy_a, done_a;
    logic [NB-1:0] data_a, sdata_a;
    logic [NB-1:0] lfsr_a = 8'h5A;
    logic [15:0]   wrap_a;

    logic [NR-1:0] req_w = '0;
    logic          reseed_w = 1'b0;
    logic [WB-1:0] seed_in_w = '0;
    logic [NR-1:0] gnt_w;
    logic          dv_w, en_w, sdv_w, busy_w, done_w;
    logic [WB-1:0] data_w, sdata_w;
    logic [WB-1:0] lfsr_w = 4'h9;
    logic [15:0]   wrap_w;

    logic [NB-1:0] m_lfsr;
    int            m_adv;
    int            m_last;
    logic [WB-1:0] m_lfsr_w;
    int            m_adv_w;

    lfsr_sched #(.NUM_BITS(NB), .NUM_REQ(NR), .STEPS(ST), .SEED(8'h00)) u_dut_a (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Req(req_a), .o_Gnt(gnt_a), .o_Data_DV(dv_a),
        .o_Data(data_a), .i_Reseed(reseed_a), .i_Seed_Data(seed_in_a),
        .o_LFSR_Enable(en_a), .o_LFSR_Seed_DV(sdv_a), .o_LFSR_Seed_Data(sdata_a),
        .i_LFSR_Data(lfsr_a), .i_LFSR_Done(done_a), .o_Busy(busy_a), .o_Wrap_Count(wrap_a)
    );

    lfsr_sched #(.NUM_BITS(WB), .NUM_REQ(NR), .STEPS(WST), .SEED(4'h0)) u_dut_w (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Req(req_w), .o_Gnt(gnt_w), .o_Data_DV(dv_w),
        .o_Data(data_w), .i_Reseed(reseed_w), .i_Seed_Data(seed_in_w),
        .o_LFSR_Enable(en_w), .o_LFSR_Seed_DV(sdv_w), .o_LFSR_Seed_Data(sdata_w),
        .i_LFSR_Data(lfsr_w), .i_LFSR_Done(done_w), .o_Busy(busy_w), .o_Wrap_Count(wrap_w)
    );

    function automatic logic [7:0] step8(input logic [7:0] v);
        return {v[6:0], ~(v[7] ^ v[5] ^ v[4] ^ v[3])};
    endfunction

    function automatic logic [3:0] step4(input logic [3:0] v);
        return {v[2:0], ~(v[3] ^ v[2])};
    endfunction

    function automatic logic [7:0] adv8(input logic [7:0] v, input int n);
        logic [7:0] r = v;
        for (int i = 0; i < n; i++) r = step8(r);
        return r;
    endfunction

    function automatic logic [3:0] adv4(input logic [3:0] v, input int n);
        logic [3:0] r = v;
        for (int i = 0; i < n; i++) r = step4(r);
        return r;
    endfunction

    function automatic int rr_pick(input int last, input logic [3:0] m);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (last + k) % 4;
            if (m[c]) return c;
        end
        return 0;
    endfunction

    function automatic logic [3:0] onehot(input int i);
        logic [3:0] r = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    // Stand-in LFSR peripherals (no reset, XNOR feedback, Done = match with seed)
    always @(posedge clk) if (en_a) lfsr_a <= sdv_a ? sdata_a : step8(lfsr_a);
    always @(posedge clk) if (en_w) lfsr_w <= sdv_w ? sdata_w : step4(lfsr_w);
    assign done_a = (lfsr_a == sdata_a);
    assign done_w = (lfsr_w == sdata_w);

    task automatic model_reset();
        m_lfsr   = 8'h00;
        m_adv    = 0;
        m_last   = NR - 1;
        m_lfsr_w = 4'h0;
        m_adv_w  = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_a = '0; reseed_a = 1'b0; req_w = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic wait_dv_a(input int budget, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (dv_a !== 1'b1 && waited < budget);
    endtask

    task automatic wait_dv_w(input int budget, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (dv_w !== 1'b1 && waited < budget);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (gnt_a !== '0)  begin errors++; $display("FAIL rst_gnt got %b want 0", gnt_a); end
        checks++; if (dv_a !== 1'b0) begin errors++; $display("FAIL rst_dv got %b want 0", dv_a); end
        checks++; if (data_a !== '0) begin errors++; $display("FAIL rst_data got %h want 0", data_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy_a); end
        checks++; if ({en_a, sdv_a} !== 2'b00) begin errors++; $display("FAIL rst_lfsr_ctl got %b want 00", {en_a, sdv_a}); end
        checks++; if (wrap_a !== 16'd0) begin errors++; $display("FAIL rst_wrap got %0d want 0", wrap_a); end
        checks++; if (sdata_a !== 8'h00) begin errors++; $display("FAIL rst_seed got %h want 00", sdata_a); end
        rst_n = 1'b1;
        model_reset();
        #1;
        checks++; if ({en_a, sdv_a} !== 2'b11) begin errors++; $display("FAIL init_ctl got %b want 11", {en_a, sdv_a}); end
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL init_busy got %b want 1", busy_a); end
        @(negedge clk);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy_a); end
        checks++; if (en_a !== 1'b0) begin errors++; $display("FAIL idle_en got %b want 0", en_a); end
        checks++; if (lfsr_a !== 8'h00) begin errors++; $display("FAIL init_seeded got %h want 00", lfsr_a); end
    endtask

    task automatic test_single();
        int waited;
        @(negedge clk);
        req_a = 4'b0001;
        wait_dv_a(20, waited);
        req_a = '0;
        m_last = rr_pick(m_last, 4'b0001);
        m_lfsr = adv8(m_lfsr, ST);
        m_adv += ST;
        checks++; if (waited != ST + 2 || dv_a !== 1'b1) begin errors++; $display("FAIL single_lat got %0d dv %b want %0d", waited, dv_a, ST + 2); end
        checks++; if (gnt_a !== 4'b0001) begin errors++; $display("FAIL single_gnt got %b want 0001", gnt_a); end
        checks++; if (data_a !== m_lfsr) begin errors++; $display("FAIL single_data got %h want %h", data_a, m_lfsr); end
        @(negedge clk);
        checks++; if ({dv_a, gnt_a} !== 5'b0) begin errors++; $display("FAIL single_pulse got dv %b gnt %b want 0", dv_a, gnt_a); end
    endtask

    task automatic test_round_robin();
        int waited;
        int idx;
        do_reset();
        @(negedge clk);
        req_a = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_dv_a(20, waited);
            idx    = rr_pick(m_last, 4'b1111);
            m_last = idx;
            m_lfsr = adv8(m_lfsr, ST);
            m_adv += ST;
            checks++; if (waited != ST + 2 || dv_a !== 1'b1) begin errors++; $display("FAIL rr_spacing[%0d] got %0d want %0d", g, waited, ST + 2); end
            checks++; if (gnt_a !== onehot(idx)) begin errors++; $display("FAIL rr_gnt[%0d] got %b want %b", g, gnt_a, onehot(idx)); end
            checks++; if (data_a !== m_lfsr) begin errors++; $display("FAIL rr_data[%0d] got %h want %h", g, data_a, m_lfsr); end
        end
        req_a = '0;
    endtask

    task automatic test_reseed();
        int waited;
        @(negedge clk);
        req_a = 4'b0001;
        @(negedge clk);
        req_a     = 4'b0010;
        reseed_a  = 1'b1;
        seed_in_a = 8'hA5;
        @(negedge clk);
        reseed_a = 1'b0;
        wait_dv_a(20, waited);
        m_last = rr_pick(m_last, 4'b0001);
        m_lfsr = adv8(m_lfsr, ST);
        checks++; if (waited != ST || gnt_a !== 4'b0001) begin errors++; $display("FAIL reseed_first got lat %0d gnt %b want %0d 0001", waited, gnt_a, ST); end
        checks++; if (data_a !== m_lfsr) begin errors++; $display("FAIL reseed_first_data got %h want %h", data_a, m_lfsr); end
        @(negedge clk);
        checks++; if ({busy_a, en_a, sdv_a} !== 3'b111) begin errors++; $display("FAIL reseed_ctl got %b want 111", {busy_a, en_a, sdv_a}); end
        checks++; if (sdata_a !== 8'hA5) begin errors++; $display("FAIL reseed_seed got %h want a5", sdata_a); end
        checks++; if (wrap_a !== 16'd0) begin errors++; $display("FAIL reseed_wrap got %0d want 0", wrap_a); end
        m_lfsr = 8'hA5;
        m_adv  = 0;
        wait_dv_a(20, waited);
        req_a  = '0;
        m_last = rr_pick(m_last, 4'b0010);
        m_lfsr = adv8(m_lfsr, ST);
        m_adv += ST;
        checks++; if (waited != ST + 3 || gnt_a !== 4'b0010) begin errors++; $display("FAIL reseed_second got lat %0d gnt %b want %0d 0010", waited, gnt_a, ST + 3); end
        checks++; if (data_a !== m_lfsr) begin errors++; $display("FAIL reseed_second_data got %h want %h", data_a, m_lfsr); end
    endtask

    task automatic test_reset_mid();
        bit saw_dv = 1'b0;
        @(negedge clk);
        req_a = 4'b0001;
        @(negedge clk);
        req_a = '0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({busy_a, dv_a} !== 2'b00) begin errors++; $display("FAIL midrst_busy_dv got %b want 00", {busy_a, dv_a}); end
        checks++; if (gnt_a !== '0 || data_a !== '0) begin errors++; $display("FAIL midrst_out got gnt %b data %h want 0", gnt_a, data_a); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        checks++; if ({en_a, sdv_a} !== 2'b11 || sdata_a !== 8'h00) begin errors++; $display("FAIL midrst_init got ctl %b seed %h want 11 00", {en_a, sdv_a}, sdata_a); end
        for (int i = 0; i < int'(ST) + 4; i++) begin
            @(negedge clk);
            if (dv_a === 1'b1) saw_dv = 1'b1;
        end
        checks++; if (saw_dv !== 1'b0) begin errors++; $display("FAIL midrst_no_dv got %b want 0", saw_dv); end
    endtask

    task automatic test_random();
        int waited;
        int idx;
        int gap;
        logic [3:0] mask;
        logic [7:0] s;
        for (int it = 0; it < 40; it++) begin
            gap = int'($urandom_range(0, 3));
            repeat (gap) @(negedge clk);
            if ($urandom_range(0, 4) == 0) begin
                s = 8'($urandom);
                if (s == 8'hFF) s = 8'h3C;
                reseed_a  = 1'b1;
                seed_in_a = s;
                @(negedge clk);
                reseed_a = 1'b0;
                @(negedge clk);
                checks++; if (sdata_a !== s || {busy_a, sdv_a} !== 2'b11) begin errors++; $display("FAIL rnd_reseed[%0d] got seed %h ctl %b want %h 11", it, sdata_a, {busy_a, sdv_a}, s); end
                m_lfsr = s;
                m_adv  = 0;
                @(negedge clk);
            end
            checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rnd_idle[%0d] got busy %b want 0", it, busy_a); end
            mask  = 4'($urandom_range(1, 15));
            req_a = mask;
            wait_dv_a(20, waited);
            req_a  = '0;
            idx    = rr_pick(m_last, mask);
            m_last = idx;
            m_lfsr = adv8(m_lfsr, ST);
            m_adv += ST;
            checks++; if (waited != ST + 2 || gnt_a !== onehot(idx)) begin errors++; $display("FAIL rnd_gnt[%0d] got lat %0d gnt %b want %0d %b", it, waited, gnt_a, ST + 2, onehot(idx)); end
            checks++; if (data_a !== m_lfsr) begin errors++; $display("FAIL rnd_data[%0d] got %h want %h", it, data_a, m_lfsr); end
            checks++; if (wrap_a !== 16'(m_adv / 255)) begin errors++; $display("FAIL rnd_wrap[%0d] got %0d want %0d", it, wrap_a, m_adv / 255); end
        end
    endtask

    task automatic test_wrap();
        int waited;
        do_reset();
        @(negedge clk);
        req_w = 4'b0001;
        for (int d = 1; d <= 3; d++) begin
            wait_dv_w(20, waited);
            m_lfsr_w = adv4(m_lfsr_w, WST);
            m_adv_w += WST;
            checks++; if (waited != WST + 2 || gnt_w !== 4'b0001 || busy_w !== 1'b0) begin errors++; $display("FAIL wrap_gnt[%0d] got lat %0d gnt %b busy %b want %0d 0001 0", d, waited, gnt_w, busy_w, WST + 2); end
            checks++; if (data_w !== m_lfsr_w) begin errors++; $display("FAIL wrap_data[%0d] got %h want %h", d, data_w, m_lfsr_w); end
            checks++; if (wrap_w !== 16'(m_adv_w / 15)) begin errors++; $display("FAIL wrap_cnt[%0d] got %0d want %0d", d, wrap_w, m_adv_w / 15); end
        end
        req_w = '0;
        checks++; if (wrap_w !== 16'd1 || data_w !== 4'h0) begin errors++; $display("FAIL wrap_third got cnt %0d data %h want 1 0", wrap_w, data_w); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_reseed();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
